// File: rtl/matraptor_pkg.sv
// Shared sizing, drain FSM encoding and beat payload for the MatRaptor row
// accumulator and its drain-side emitter.
package matraptor_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned IDX_W   = 16;
  localparam int unsigned NQ      = 8;
  localparam int unsigned Q_DEPTH = 256;
  localparam int unsigned CHUNK_W = 32;

  localparam int unsigned ADDR_W  = $clog2(NQ * Q_DEPTH);
  localparam int unsigned NCHUNK  = (NQ * Q_DEPTH) / CHUNK_W;
  localparam int unsigned CIDX_W  = $clog2(NCHUNK);
  localparam int unsigned BIT_W   = $clog2(CHUNK_W);

  typedef enum logic [2:0] {
    DS_IDLE     = 3'd0,
    DS_VB_REQ   = 3'd1,
    DS_VB_WAIT  = 3'd2,
    DS_SCAN     = 3'd3,
    DS_VAL_WAIT = 3'd4,
    DS_EMIT     = 3'd5,
    DS_FINAL    = 3'd6,
    DS_DONE     = 3'd7
  } drain_state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  col;
    logic [DATA_W-1:0] val;
  } beat_t;

endpackage

// File: rtl/find_first_set.sv
// Combinational lowest-set-bit encoder; idx is 0 when no bit is set.
module find_first_set #(
  parameter  int unsigned W  = 32,
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  bits,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top so the lowest set bit wins
  always_comb begin
    idx = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (bits[i]) idx = IW'(i);
    end
  end

  assign any = |bits;

endmodule

// File: rtl/row_drain_emitter.sv
// Drains one accumulated row: scans the valid-bit bitmap chunk by chunk,
// reads each value and streams (row, col, val) beats in ascending column order.
module row_drain_emitter
  import matraptor_pkg::*;
#(
  parameter  int unsigned DATA_W  = matraptor_pkg::DATA_W,
  parameter  int unsigned IDX_W   = matraptor_pkg::IDX_W,
  parameter  int unsigned NQ      = matraptor_pkg::NQ,
  parameter  int unsigned Q_DEPTH = matraptor_pkg::Q_DEPTH,
  parameter  int unsigned CHUNK_W = matraptor_pkg::CHUNK_W,
  localparam int unsigned ADDR_W  = $clog2(NQ * Q_DEPTH),
  localparam int unsigned NCHUNK  = (NQ * Q_DEPTH) / CHUNK_W,
  localparam int unsigned CIDX_W  = $clog2(NCHUNK),
  localparam int unsigned BIT_W   = $clog2(CHUNK_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_req,
  input  logic [IDX_W-1:0]  flush_row,
  output logic              flush_ack,
  output logic              busy,
  output logic              flush_done,
  output logic              flush_empty,
  output logic              vb_rd_en,
  output logic [CIDX_W-1:0] vb_rd_idx,
  input  logic [CHUNK_W-1:0] vb_rd_data,
  output logic              val_rd_en,
  output logic [ADDR_W-1:0] val_rd_addr,
  input  logic [DATA_W-1:0] val_rd_data,
  output logic              clr_en,
  output logic [CIDX_W-1:0] clr_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_row,
  output logic [IDX_W-1:0]  out_col,
  output logic [DATA_W-1:0] out_val,
  output logic              out_last
);

  localparam logic [2:0] ST_IDLE     = 3'(DS_IDLE);
  localparam logic [2:0] ST_VB_REQ   = 3'(DS_VB_REQ);
  localparam logic [2:0] ST_VB_WAIT  = 3'(DS_VB_WAIT);
  localparam logic [2:0] ST_SCAN     = 3'(DS_SCAN);
  localparam logic [2:0] ST_VAL_WAIT = 3'(DS_VAL_WAIT);
  localparam logic [2:0] ST_EMIT     = 3'(DS_EMIT);
  localparam logic [2:0] ST_FINAL    = 3'(DS_FINAL);
  localparam logic [2:0] ST_DONE     = 3'(DS_DONE);

  localparam logic [CIDX_W-1:0] LAST_CHUNK = CIDX_W'(NCHUNK - 1);

  logic [2:0]         state_q, state_d;
  logic [CIDX_W-1:0]  chunk_q, chunk_d;
  logic [CHUNK_W-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0]  col_q, col_d;
  logic [IDX_W-1:0]   row_q, row_d;
  logic               pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0]  pend_col_q, pend_col_d;
  logic [DATA_W-1:0]  pend_val_q, pend_val_d;
  logic [ADDR_W-1:0]  stg_col_q, stg_col_d;
  logic [DATA_W-1:0]  stg_val_q, stg_val_d;

  logic               out_valid_d, out_last_d, flush_empty_d;
  logic [IDX_W-1:0]   out_col_d;
  logic [DATA_W-1:0]  out_val_d;
  logic               advance;
  logic [BIT_W-1:0]   nxt_bit;
  logic               nxt_any;

  // Local copy of the chunk's valid bits, consumed lowest bit first
  always_comb begin
    mask_d = mask_q;
    if (state_q == ST_VB_WAIT) begin
      mask_d = vb_rd_data;
    end else if (state_q == ST_SCAN && (|mask_q)) begin
      mask_d = mask_q & (mask_q - CHUNK_W'(1));
    end
  end

  find_first_set #(.W(CHUNK_W)) u_ffs (
    .bits (mask_d),
    .idx  (nxt_bit),
    .any  (nxt_any)
  );

  // Bits are owned by the local mask once the read data arrives
  assign clr_en  = (state_q == ST_VB_WAIT) && (|vb_rd_data);
  assign clr_idx = chunk_q;

  always_comb begin
    state_d       = state_q;
    chunk_d       = chunk_q;
    col_d         = col_q;
    row_d         = row_q;
    pend_valid_d  = pend_valid_q;
    pend_col_d    = pend_col_q;
    pend_val_d    = pend_val_q;
    stg_col_d     = stg_col_q;
    stg_val_d     = stg_val_q;
    out_valid_d   = out_valid;
    out_col_d     = out_col;
    out_val_d     = out_val;
    out_last_d    = out_last;
    flush_empty_d = 1'b0;
    advance       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (flush_req && flush_ack) begin
          row_d        = flush_row;
          chunk_d      = '0;
          pend_valid_d = 1'b0;
          state_d      = ST_VB_REQ;
        end
      end
      ST_VB_REQ:  state_d = ST_VB_WAIT;
      ST_VB_WAIT: advance = 1'b1;
      ST_SCAN: begin
        if (|mask_q) begin
          col_d   = val_rd_addr;
          state_d = ST_VAL_WAIT;
        end else begin
          advance = 1'b1;
        end
      end
      ST_VAL_WAIT: begin
        if (!pend_valid_q) begin
          pend_col_d   = col_q;
          pend_val_d   = val_rd_data;
          pend_valid_d = 1'b1;
          advance      = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_col_d   = IDX_W'(pend_col_q);
          out_val_d   = pend_val_q;
          out_last_d  = 1'b0;
          stg_col_d   = col_q;
          stg_val_d   = val_rd_data;
          state_d     = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          pend_col_d  = stg_col_q;
          pend_val_d  = stg_val_q;
          advance     = 1'b1;
        end
      end
      ST_FINAL: begin
        if (!pend_valid_q) begin
          flush_empty_d = 1'b1;
          state_d       = ST_DONE;
        end else if (out_valid && out_ready) begin
          out_valid_d  = 1'b0;
          out_last_d   = 1'b0;
          pend_valid_d = 1'b0;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Empty masks skip SCAN so a bare chunk costs only the read and wait cycles
    if (advance) begin
      if (nxt_any) begin
        state_d = ST_SCAN;
      end else if (chunk_q == LAST_CHUNK) begin
        state_d = ST_FINAL;
        if (pend_valid_d) begin
          out_valid_d = 1'b1;
          out_col_d   = IDX_W'(pend_col_d);
          out_val_d   = pend_val_d;
          out_last_d  = 1'b1;
        end
      end else begin
        chunk_d = chunk_q + CIDX_W'(1);
        state_d = ST_VB_REQ;
      end
    end
  end

  // Strobes are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      chunk_q      <= '0;
      mask_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_col_q   <= '0;
      pend_val_q   <= '0;
      stg_col_q    <= '0;
      stg_val_q    <= '0;
      flush_ack    <= 1'b0;
      busy         <= 1'b0;
      flush_done   <= 1'b0;
      flush_empty  <= 1'b0;
      vb_rd_en     <= 1'b0;
      vb_rd_idx    <= '0;
      val_rd_en    <= 1'b0;
      val_rd_addr  <= '0;
      out_valid    <= 1'b0;
      out_row      <= '0;
      out_col      <= '0;
      out_val      <= '0;
      out_last     <= 1'b0;
    end else begin
      state_q      <= state_d;
      chunk_q      <= chunk_d;
      mask_q       <= mask_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pend_valid_q <= pend_valid_d;
      pend_col_q   <= pend_col_d;
      pend_val_q   <= pend_val_d;
      stg_col_q    <= stg_col_d;
      stg_val_q    <= stg_val_d;
      flush_ack    <= (state_d == ST_IDLE);
      busy         <= (state_d != ST_IDLE);
      flush_done   <= (state_d == ST_DONE);
      flush_empty  <= flush_empty_d;
      vb_rd_en     <= (state_d == ST_VB_REQ);
      vb_rd_idx    <= chunk_d;
      val_rd_en    <= (state_d == ST_SCAN);
      val_rd_addr  <= ADDR_W'({chunk_d, nxt_bit});
      out_valid    <= out_valid_d;
      out_row      <= row_d;
      out_col      <= out_col_d;
      out_val      <= out_val_d;
      out_last     <= out_last_d;
    end
  end

endmodule

// File: tb/tb_row_drain_emitter.sv
// Directed bench for row_drain_emitter: bitmap/value memories, a column-order
// scoreboard and per-cycle handshake/stability checks.
module tb_row_drain_emitter;
  import matraptor_pkg::*;

  localparam int unsigned NCOL = NQ * Q_DEPTH;

  typedef struct packed {
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic [DATA_W-1:0] val;
    logic              last;
  } obs_t;

  logic               clk, rst_n;
  logic               flush_req;
  logic [IDX_W-1:0]   flush_row;
  logic               flush_ack, busy, flush_done, flush_empty;
  logic               vb_rd_en;
  logic [CIDX_W-1:0]  vb_rd_idx;
  logic [CHUNK_W-1:0] vb_rd_data;
  logic               val_rd_en;
  logic [ADDR_W-1:0]  val_rd_addr;
  logic [DATA_W-1:0]  val_rd_data;
  logic               clr_en;
  logic [CIDX_W-1:0]  clr_idx;
  logic               out_valid, out_ready, out_last;
  logic [IDX_W-1:0]   out_row, out_col;
  logic [DATA_W-1:0]  out_val;

  row_drain_emitter dut (
    .clk(clk), .rst_n(rst_n),
    .flush_req(flush_req), .flush_row(flush_row), .flush_ack(flush_ack),
    .busy(busy), .flush_done(flush_done), .flush_empty(flush_empty),
    .vb_rd_en(vb_rd_en), .vb_rd_idx(vb_rd_idx), .vb_rd_data(vb_rd_data),
    .val_rd_en(val_rd_en), .val_rd_addr(val_rd_addr), .val_rd_data(val_rd_data),
    .clr_en(clr_en), .clr_idx(clr_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_col(out_col), .out_val(out_val), .out_last(out_last)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d @%0t", name, got, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Accumulator memories: 1-cycle read latency, chunk clear on clr_en
  logic [CHUNK_W-1:0] bitmap [NCHUNK];
  logic [DATA_W-1:0]  vals   [NCOL];
  always @(posedge clk) begin
    if (vb_rd_en)  vb_rd_data  <= bitmap[vb_rd_idx];
    if (val_rd_en) val_rd_data <= vals[val_rd_addr];
    if (clr_en)    bitmap[clr_idx] = '0;
  end

  // Model state
  beat_t          exp_q[$];
  int             exp_clr[$];
  logic [IDX_W-1:0] exp_row;
  obs_t           got_q[$];
  int             clr_q[$];
  int got_n = 0, vb_cnt = 0, done_cnt = 0, acc_cnt = 0, stall_cnt = 0;
  int acc_cyc = 0, done_cyc = 0;
  logic done_empty = 1'b0;
  logic mon_en = 1'b0;
  int rdy_mode = 0;
  int stall_left = 0;

  // Downstream ready pattern, changed just after each rising edge
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       out_ready = ~out_ready;
      2: begin
        if (out_valid && got_n == 2 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  // Per-cycle compare against the scoreboard
  logic prev_stall = 1'b0;
  logic [IDX_W-1:0]  prev_col, prev_row;
  logic [DATA_W-1:0] prev_val;
  logic              prev_last;
  always @(negedge clk) begin
    if (mon_en) begin
      if (vb_rd_en) vb_cnt++;
      if (clr_en) clr_q.push_back(int'(clr_idx));
      if (clr_en || val_rd_en) chk("clr_rd_overlap", 32'(clr_en && val_rd_en), 32'(0));
      if (flush_req && flush_ack) begin acc_cnt++; acc_cyc = cyc; end
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'(1));
        chk("hold_col",   32'(out_col),   32'(prev_col));
        chk("hold_row",   32'(out_row),   32'(prev_row));
        chk("hold_val",   out_val,        prev_val);
        chk("hold_last",  32'(out_last),  32'(prev_last));
        chk("stall_rd",   32'(val_rd_en), 32'(0));
      end
      if (out_valid && !out_ready && got_n == 2) stall_cnt++;
      if (out_valid && out_ready) begin
        if (got_n < exp_q.size()) begin
          chk("beat_col",  32'(out_col),  32'(exp_q[got_n].col));
          chk("beat_val",  out_val,       exp_q[got_n].val);
          chk("beat_row",  32'(out_row),  32'(exp_row));
          chk("beat_last", 32'(out_last), 32'(got_n == exp_q.size() - 1));
        end else begin
          chk("beat_overflow", 32'(got_n), 32'(exp_q.size()));
        end
        got_q.push_back('{row: out_row, col: out_col, val: out_val, last: out_last});
        got_n++;
      end
      if (flush_done) begin
        done_cnt++;
        done_empty = flush_empty;
        done_cyc   = cyc;
        chk("busy_at_done", 32'(busy), 32'(1));
      end
      prev_stall = out_valid && !out_ready;
      prev_col = out_col; prev_row = out_row; prev_val = out_val; prev_last = out_last;
    end
  end

  task automatic clear_mem();
    for (int c = 0; c < int'(NCHUNK); c++) bitmap[c] = '0;
    for (int i = 0; i < int'(NCOL); i++) vals[i] = '0;
  endtask

  task automatic set_entry(input int col, input logic [DATA_W-1:0] v);
    bitmap[col / CHUNK_W][col % CHUNK_W] = 1'b1;
    vals[col] = v;
  endtask

  task automatic start_flush(input logic [IDX_W-1:0] row);
    exp_q.delete(); exp_clr.delete(); got_q.delete(); clr_q.delete();
    for (int c = 0; c < int'(NCOL); c++)
      if (bitmap[c / CHUNK_W][c % CHUNK_W])
        exp_q.push_back('{col: IDX_W'(c), val: vals[c]});
    for (int k = 0; k < int'(NCHUNK); k++)
      if (bitmap[k] != '0) exp_clr.push_back(k);
    exp_row = row;
    got_n = 0; vb_cnt = 0; done_cnt = 0; acc_cnt = 0; stall_cnt = 0;
    @(posedge clk); #1;
    flush_row = row;
    flush_req = 1'b1;
    for (int i = 0; i < 20 && acc_cnt == 0; i++) @(posedge clk);
    chk("accepted", 32'(acc_cnt), 32'(1));
    #1 flush_req = 1'b0;
  endtask

  task automatic finish_flush(input int bound);
    logic any_left;
    for (int i = 0; i < bound && done_cnt == 0; i++) @(posedge clk);
    if (done_cnt == 0) chk("done_timeout", 32'(done_cnt), 32'(1));
    repeat (3) @(negedge clk);
    chk("done_pulses", 32'(done_cnt), 32'(1));
    chk("busy_after",  32'(busy), 32'(0));
    chk("beat_count",  32'(got_n), 32'(exp_q.size()));
    chk("flush_empty", 32'(done_empty), 32'(exp_q.size() == 0));
    chk("vb_reads",    32'(vb_cnt), 32'(NCHUNK));
    chk("clr_count",   32'(clr_q.size()), 32'(exp_clr.size()));
    for (int k = 0; k < clr_q.size() && k < exp_clr.size(); k++)
      chk("clr_idx", 32'(clr_q[k]), 32'(exp_clr[k]));
    any_left = 1'b0;
    for (int k = 0; k < int'(NCHUNK); k++) if (bitmap[k] != '0) any_left = 1'b1;
    chk("bitmap_cleared", 32'(any_left), 32'(0));
  endtask

  int lasts;

  initial begin
    #500000;
    $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush_req = 1'b0; flush_row = '0; out_ready = 1'b1;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_ack",   32'(flush_ack), 32'(0));
    chk("rst_busy",  32'(busy),      32'(0));
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_vbrd",  32'(vb_rd_en),  32'(0));
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ack", 32'(flush_ack), 32'(1));

    // Empty row
    start_flush(16'd5);
    finish_flush(400);
    chk("empty_latency", 32'(done_cyc - acc_cyc), 32'(130));
    chk("empty_flag", 32'(done_empty), 32'(1));
    chk("empty_clr", 32'(clr_q.size()), 32'(0));

    // Single entry at col 0
    clear_mem();
    set_entry(0, 32'd7);
    start_flush(16'd3);
    finish_flush(400);
    if (got_q.size() == 1) begin
      chk("single_row",  32'(got_q[0].row),  32'(3));
      chk("single_col",  32'(got_q[0].col),  32'(0));
      chk("single_val",  got_q[0].val,       32'd7);
      chk("single_last", 32'(got_q[0].last), 32'(1));
    end else chk("single_n", 32'(got_q.size()), 32'(1));
    chk("single_clr0", 32'(clr_q.size() > 0 ? clr_q[0] : -1), 32'(0));
    chk("single_nonempty", 32'(done_empty), 32'(0));

    // Chunk-edge columns; flush_req during the drain must be ignored
    clear_mem();
    set_entry(1, 32'd10); set_entry(31, 32'd20); set_entry(32, 32'd30); set_entry(2047, 32'd40);
    start_flush(16'd3);
    repeat (10) @(posedge clk);
    #1 flush_row = 16'd9; flush_req = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("ack_while_busy", 32'(flush_ack), 32'(0));
    end
    flush_req = 1'b0;
    finish_flush(1000);
    chk("busy_acc_once", 32'(acc_cnt), 32'(1));
    if (got_q.size() == 4) begin
      chk("edge_col0", 32'(got_q[0].col), 32'(1));
      chk("edge_col1", 32'(got_q[1].col), 32'(31));
      chk("edge_col2", 32'(got_q[2].col), 32'(32));
      chk("edge_col3", 32'(got_q[3].col), 32'(2047));
      chk("edge_val3", got_q[3].val, 32'd40);
      chk("edge_last2", 32'(got_q[2].last), 32'(0));
      chk("edge_last3", 32'(got_q[3].last), 32'(1));
      chk("edge_row", 32'(got_q[1].row), 32'(3));
    end else chk("edge_n", 32'(got_q.size()), 32'(4));
    if (clr_q.size() == 3) begin
      chk("edge_clr0", 32'(clr_q[0]), 32'(0));
      chk("edge_clr1", 32'(clr_q[1]), 32'(1));
      chk("edge_clr2", 32'(clr_q[2]), 32'(63));
    end else chk("edge_clr_n", 32'(clr_q.size()), 32'(3));

    // Full chunk 5 with toggling ready
    clear_mem();
    for (int c = 160; c < 192; c++) set_entry(c, DATA_W'(c));
    rdy_mode = 1;
    start_flush(16'd11);
    finish_flush(2000);
    rdy_mode = 0;
    lasts = 0;
    foreach (got_q[i]) if (got_q[i].last) lasts++;
    chk("full_n", 32'(got_q.size()), 32'(32));
    if (got_q.size() == 32) begin
      chk("full_first", 32'(got_q[0].col), 32'(160));
      chk("full_lastcol", 32'(got_q[31].col), 32'(191));
      chk("full_lastflag", 32'(got_q[31].last), 32'(1));
    end
    chk("full_lasts", 32'(lasts), 32'(1));

    // Five-cycle stall on beat 2
    clear_mem();
    set_entry(1, 32'd10); set_entry(31, 32'd20); set_entry(32, 32'd30); set_entry(2047, 32'd40);
    stall_left = 5;
    rdy_mode = 2;
    start_flush(16'd6);
    finish_flush(1000);
    rdy_mode = 0;
    chk("stall_cycles", 32'(stall_cnt), 32'(5));
    chk("stall_n", 32'(got_q.size()), 32'(4));

    // Reset in the middle of a drain
    clear_mem();
    for (int c = 160; c < 192; c++) set_entry(c, DATA_W'(c));
    start_flush(16'd4);
    for (int i = 0; i < 500 && got_n < 3; i++) @(posedge clk);
    chk("pre_reset_beats", 32'(got_n >= 3), 32'(1));
    @(negedge clk);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'(0));
    chk("rst_mid_busy",  32'(busy),      32'(0));
    chk("rst_mid_clr",   32'(clr_en),    32'(0));
    chk("rst_mid_rd",    32'(val_rd_en), 32'(0));
    repeat (3) @(negedge clk);
    done_cnt = 0;
    prev_stall = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt), 32'(0));
    chk("rst_ack_back", 32'(flush_ack), 32'(1));

    clear_mem();
    set_entry(100, 32'd55);
    start_flush(16'd8);
    finish_flush(400);
    if (got_q.size() == 1) begin
      chk("post_rst_col", 32'(got_q[0].col), 32'(100));
      chk("post_rst_val", got_q[0].val, 32'd55);
      chk("post_rst_row", 32'(got_q[0].row), 32'(8));
    end else chk("post_rst_n", 32'(got_q.size()), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/row_drain_emitter.md
Name: row_drain_emitter

Overview:
- Read-side counterpart of the direct-mapped row accumulator. After the accumulator finishes a row, it issues a flush request.
- The block scans the accumulator's valid-bit bitmap chunk by chunk, reads each accumulated value, and streams (row, col, val) beats in ascending column order on a valid/ready interface, marking the final beat with out_last.
- It clears the bitmap behind itself, so the accumulator's valid-bit state is empty when flush_done pulses.

Parameters:
- DATA_W, 32, accumulated value width
- IDX_W, 16, row/column index width
- NQ, 8, accumulator queues; column bits [10:8] select the queue
- Q_DEPTH, 256, entries per queue; column bits [7:0] select the slot
- CHUNK_W, 32, valid bits returned per bitmap read; must divide NQ*Q_DEPTH
- Derived: ADDR_W = clog2(NQ*Q_DEPTH) = 11; NCHUNK = NQ*Q_DEPTH/CHUNK_W = 64; CIDX_W = clog2(NCHUNK) = 6; BIT_W = clog2(CHUNK_W) = 5

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_req  in  1  request to drain the current row
- flush_row  in  IDX_W  row id to tag the beats with; sampled on accept
- flush_ack  out  1  high only in IDLE; accept = flush_req && flush_ack
- busy  out  1  high from accept until the cycle after flush_done
- flush_done  out  1  one-cycle pulse when the drain is complete
- flush_empty  out  1  valid with flush_done; 1 = row had no entries
- vb_rd_en  out  1  bitmap chunk read strobe
- vb_rd_idx  out  CIDX_W  chunk index
- vb_rd_data  in  CHUNK_W  chunk bits; valid the cycle after vb_rd_en
- val_rd_en  out  1  value read strobe
- val_rd_addr  out  ADDR_W  {queue, slot} = column[10:0]
- val_rd_data  in  DATA_W  value; valid the cycle after val_rd_en
- clr_en  out  1  clear all valid bits of one chunk
- clr_idx  out  CIDX_W  chunk to clear
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- out_row  out  IDX_W  equals the latched flush_row
- out_col  out  IDX_W  chunk*CHUNK_W + bit, zero-extended
- out_val  out  DATA_W  accumulated value
- out_last  out  1  final beat of the row

Behaviour:
- Reset (asynchronous, rst_n low):
  - state returns to IDLE; pend_valid=0.
  - All outputs are 0: flush_ack=0 during reset, and it rises in IDLE once reset is released.
  - Reset mid-drain abandons the drain: no further clr or rd strobes, and no flush_done is produced.
- FSM states: IDLE, VB_REQ, VB_WAIT, SCAN, VAL_WAIT, EMIT, FINAL, DONE.
- IDLE:
  - flush_ack=1.
  - On accept: latch flush_row, set chunk=0, pend_valid=0, go to VB_REQ.
  - flush_req outside IDLE is ignored (ack=0).
- VB_REQ: assert vb_rd_en with vb_rd_idx=chunk; go to VB_WAIT.
- VB_WAIT:
  - Capture vb_rd_data into the local mask.
  - If mask≠0: pulse clr_en with clr_idx=chunk in this cycle. The bits are now owned by the local mask.
  - Go to SCAN.
- SCAN:
  - If mask≠0: take b = lowest set bit, assert val_rd_en with val_rd_addr = chunk*CHUNK_W+b, clear bit b in the mask, latch the column, go to VAL_WAIT.
  - Else if chunk==NCHUNK-1: go to FINAL.
  - Else: chunk++ and go to VB_REQ.
- VAL_WAIT:
  - If pend_valid=0: load {col, val_rd_data} into the pending register, set pend_valid=1, go to SCAN.
  - If pend_valid=1: present the pending beat on out_* with out_last=0, hold the new beat in the staging register, go to EMIT.
- EMIT:
  - out_valid=1; all out_* are held stable while out_ready=0.
  - On out_valid&&out_ready: pending <= staging, go to SCAN.
- FINAL:
  - If pend_valid: present the pending beat with out_last=1, hold until out_ready, then go to DONE.
  - If !pend_valid: go directly to DONE with flush_empty=1.
- DONE: pulse flush_done for 1 cycle, then go to IDLE.
- Guarantees:
  - Beats are emitted in strictly ascending column order.
  - Exactly one out_last per non-empty row; none for an empty row.
- Timing:
  - Each chunk costs 2 cycles (VB_REQ, VB_WAIT) plus 2 cycles per set bit, plus backpressure stalls.
  - An empty row drains in 2*NCHUNK+2 cycles from accept to flush_done.
- Width rules:
  - out_col is zero-extended to IDX_W.
  - Columns ≥ NQ*Q_DEPTH are never produced.
- Simultaneous events:
  - out_ready high on the first out_valid cycle gives a single-cycle EMIT.
  - clr_en and val_rd_en never assert in the same cycle. clr_en occurs only in VB_WAIT; val_rd_en only in SCAN.

Decomposition:
- matraptor_pkg holds:
  - DATA_W/IDX_W defaults and the derived ADDR_W/NCHUNK/CIDX_W/BIT_W localparams
  - the drain_state_t enum
  - the beat_t packed struct {col, val}, shared with the accumulator
- Sub-module find_first_set #(W=CHUNK_W):
  - combinational lowest-set-bit encoder
  - outputs: index (BIT_W bits) and any flag

Test Plan:
- Empty bitmap, flush_req with row=5 -> 64 vb reads, 0 clr_en, no out_valid, flush_done+flush_empty after 130 cycles.
- Single entry col 0, val 7, row 3 -> one beat (3,0,7,last=1), clr_idx=0 once, flush_empty=0.
- Entries col 1/31/32/2047 with vals 10/20/30/40 -> beats in that order, last only on col 2047, clears on chunks 0, 1, 63.
- Chunk 5 fully set, vals = col -> 32 beats with cols 160..191, only col 191 has last; out_ready toggling 1/0 -> no beat lost or duplicated.
- out_ready held low 5 cycles on beat 2 -> out_* stable throughout, no val_rd_en during the stall, then the stream resumes.
- flush_req during busy -> ignored; rst_n low mid-drain -> out_valid=0 and busy=0 immediately, no flush_done, next flush accepted cleanly.
